geofence_poly: RTL

Parametrised point-in-convex-polygon detector, the next generation of the fixed six-receiver geofence engine. It accepts one target point followed by `N` receiver vertices in arbitrary order through a valid/ready stream. It sorts the vertices angularly around vertex 0 with a shared cross-product unit, then tests the target against every polygon edge. It reports inside, outside or on-edge with a one-cycle `valid` pulse, and sits between the coordinate front-end and the alarm/decision logic.

---
 rtl/geofence_pkg.sv | 20 ++
 rtl/geofence_poly_if.sv | 24 ++
 rtl/geofence_cross.sv | 35 +++
 rtl/geofence_poly.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/geofence_pkg.sv
// geofence_poly shared types
// FSM states and arithmetic width helpers
package geofence_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DETECT,
    DONE
  } state_t;

  function automatic int prod_w(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int diff_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/geofence_poly_if.sv
// geofence_poly stream interface
// coordinate beats in, result strobe out
interface geofence_poly_if #(
  parameter int W = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         edge_mode;
  logic         valid;
  logic         is_inside;
  logic         on_edge;

  modport master (
    output in_valid, X, Y, edge_mode,
    input  in_ready, valid, is_inside, on_edge
  );

  modport slave (
    input  in_valid, X, Y, edge_mode,
    output in_ready, valid, is_inside, on_edge
  );
endinterface

// File: rtl/geofence_cross.sv
// geofence_cross: exact signed cross product
// (p1-o) x (p2-o), reports sign only
module geofence_cross
  import geofence_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] ox,
  input  logic [W-1:0] oy,
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  output logic         pos,
  output logic         zero
);
  localparam int DW = diff_w(W);
  localparam int PW = prod_w(W);

  logic signed [DW-1:0] dax, day;
  logic signed [DW-1:0] dbx, dby;
  logic signed [PW-1:0] c;

  assign dax = $signed({1'b0, ax}) - $signed({1'b0, ox});
  assign day = $signed({1'b0, ay}) - $signed({1'b0, oy});
  assign dbx = $signed({1'b0, bx}) - $signed({1'b0, ox});
  assign dby = $signed({1'b0, by}) - $signed({1'b0, oy});

  // both products and their difference fit in PW bits
  assign c = PW'(dax) * PW'(dby)
           - PW'(day) * PW'(dbx);

  assign zero = (c == '0);
  assign pos  = !c[PW-1] && !zero;
endmodule

// File: rtl/geofence_poly.sv
// geofence_poly: point-in-convex-polygon test
// load, angular sort around v0, edge sweep
module geofence_poly
  import geofence_pkg::*;
#(
  parameter int W = 10,
  parameter int N = 6
) (
  input logic      clk,
  input logic      reset,
  geofence_poly_if.slave bus
);
  localparam int VW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  state_t state_q, state_d;

  logic [W-1:0]  vx [N];
  logic [W-1:0]  vy [N];
  logic [W-1:0]  tx, ty;
  logic          em_q, zf_q;
  logic          inside_q, edge_q;
  logic [CW-1:0] cnt_q;
  logic [VW-1:0] i_q, j_q, k_q;
  logic [VW-1:0] k_nx, vidx;

  logic [W-1:0]  ox, oy, ax, ay, bx, by;
  logic          c_pos, c_zero;
  logic          take, last_beat;
  logic          sort_end, det_last;
  logic          zf_all;

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.valid     = (state_q == DONE);
  assign bus.is_inside = inside_q;
  assign bus.on_edge   = edge_q;

  assign take      = bus.in_valid && bus.in_ready;
  assign last_beat = take && (cnt_q == CW'(N));
  assign vidx      = VW'(cnt_q - 1'b1);
  assign sort_end  = (i_q == VW'(N - 2))
                  && (j_q == VW'(N - 1));
  assign det_last  = (k_q == VW'(N - 1));
  assign k_nx      = det_last ? '0 : k_q + 1'b1;
  assign zf_all    = zf_q || c_zero;

  // one cross unit shared by sort and detect
  always_comb begin
    ox = vx[0];
    oy = vy[0];
    ax = vx[i_q];
    ay = vy[i_q];
    bx = vx[j_q];
    by = vy[j_q];
    if (state_q == DETECT) begin
      ox = tx;
      oy = ty;
      ax = vx[k_q];
      ay = vy[k_q];
      bx = vx[k_nx];
      by = vy[k_nx];
    end
  end

  geofence_cross #(.W(W)) u_cross (
    .ox   (ox),
    .oy   (oy),
    .ax   (ax),
    .ay   (ay),
    .bx   (bx),
    .by   (by),
    .pos  (c_pos),
    .zero (c_zero)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:   if (last_beat) state_d = SORT;
      SORT:   if (sort_end) state_d = DETECT;
      DETECT: if (c_pos || det_last) state_d = DONE;
      DONE:   state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N; n++) begin
        vx[n] <= '0;
        vy[n] <= '0;
      end
      tx       <= '0;
      ty       <= '0;
      em_q     <= 1'b0;
      zf_q     <= 1'b0;
      inside_q <= 1'b0;
      edge_q   <= 1'b0;
      cnt_q    <= '0;
      i_q      <= VW'(1);
      j_q      <= VW'(2);
      k_q      <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          i_q <= VW'(1);
          j_q <= VW'(2);
          k_q <= '0;
          if (take) begin
            if (cnt_q == '0) begin
              tx   <= bus.X;
              ty   <= bus.Y;
              em_q <= bus.edge_mode;
              zf_q <= 1'b0;
            end else begin
              vx[vidx] <= bus.X;
              vy[vidx] <= bus.Y;
            end
            cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
          end
        end
        SORT: begin
          if (c_pos) begin
            vx[i_q] <= vx[j_q];
            vy[i_q] <= vy[j_q];
            vx[j_q] <= vx[i_q];
            vy[j_q] <= vy[i_q];
          end
          if (j_q == VW'(N - 1)) begin
            i_q <= i_q + 1'b1;
            j_q <= i_q + VW'(2);
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        DETECT: begin
          zf_q <= zf_all;
          k_q  <= k_nx;
          if (c_pos) begin
            inside_q <= 1'b0;
            edge_q   <= 1'b0;
          end else if (det_last) begin
            edge_q   <= zf_all;
            inside_q <= zf_all ? em_q : 1'b1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end
endmodule
